// File: rtl/pulse_train_gen_if.sv
// Pulse-train generator bus: per-channel start/stop requests, packed
// configuration fields and the generated waveform/status outputs.
// Optional PULSE_TRAIN_POL_EN adds a per-channel polarity input.
//   master : drives start, stop, mode, high_len, low_len, pulse_cnt (+polarity)
//   slave  : drives signal, busy, done
interface pulse_train_gen_if #(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned CNT_W    = 8
);
   logic [CHANNELS-1:0]       start;
   logic [CHANNELS-1:0]       stop;
   logic [CHANNELS-1:0]       mode;
   logic [CHANNELS*CNT_W-1:0] high_len;
   logic [CHANNELS*CNT_W-1:0] low_len;
   logic [CHANNELS*CNT_W-1:0] pulse_cnt;
`ifdef PULSE_TRAIN_POL_EN
   logic [CHANNELS-1:0]       polarity;
`endif
   logic [CHANNELS-1:0]       signal;
   logic [CHANNELS-1:0]       busy;
   logic [CHANNELS-1:0]       done;

`ifdef PULSE_TRAIN_POL_EN
   modport master (output start, stop, mode, high_len, low_len, pulse_cnt, polarity,
                   input  signal, busy, done);
   modport slave  (input  start, stop, mode, high_len, low_len, pulse_cnt, polarity,
                   output signal, busy, done);
`else
   modport master (output start, stop, mode, high_len, low_len, pulse_cnt,
                   input  signal, busy, done);
   modport slave  (input  start, stop, mode, high_len, low_len, pulse_cnt,
                   output signal, busy, done);
`endif
endinterface

// File: rtl/pulse_train_gen.sv
// Multi-channel programmable pulse-train generator. Each channel runs its own
// IDLE/HIGH/LOW machine producing bursts (mode=0) or continuous trains (mode=1).
// Configuration is latched at start; all outputs are registered.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : pulse_train_gen_if.slave (start/stop/config in, signal/busy/done out)
// Optional feature macro: PULSE_TRAIN_POL_EN (per-channel output polarity).
module pulse_train_gen #(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned CNT_W    = 8
) (
   input logic               clock,
   input logic               reset_n,
   pulse_train_gen_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } state_e;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      state_e           state_q;
      logic [CNT_W-1:0] phase_q;   // cycles left in current phase, minus one
      logic [CNT_W-1:0] pulses_q;  // pulses left after the current one (burst)
      logic [CNT_W-1:0] high_q;
      logic [CNT_W-1:0] low_q;
      logic             mode_q;
      logic             pol_q;
      logic             signal_q;
      logic             busy_q;
      logic             done_q;

      logic [CNT_W-1:0] high_in;
      logic [CNT_W-1:0] low_in;
      logic [CNT_W-1:0] cnt_in;
      logic             pol_in;
      logic             start_ok;

      assign high_in = bus.high_len[g*CNT_W +: CNT_W];
      assign low_in  = bus.low_len[g*CNT_W +: CNT_W];
      assign cnt_in  = bus.pulse_cnt[g*CNT_W +: CNT_W];
`ifdef PULSE_TRAIN_POL_EN
      assign pol_in  = bus.polarity[g];
`else
      assign pol_in  = 1'b0;
`endif

      // Zero-length or zero-count requests are dropped; stop beats start.
      assign start_ok = bus.start[g] && !bus.stop[g] && (high_in != '0) &&
                        (bus.mode[g] || (cnt_in != '0));

      // Channel FSM with registered outputs; idle level follows latched polarity.
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            pulses_q <= '0;
            high_q   <= '0;
            low_q    <= '0;
            mode_q   <= 1'b0;
            pol_q    <= 1'b0;
            signal_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
         end else begin
            done_q <= 1'b0;
            case (state_q)
               ST_IDLE: begin
                  if (start_ok) begin
                     high_q   <= high_in;
                     low_q    <= low_in;
                     mode_q   <= bus.mode[g];
                     pol_q    <= pol_in;
                     phase_q  <= high_in - CNT_W'(1);
                     pulses_q <= cnt_in - CNT_W'(1);
                     state_q  <= ST_HIGH;
                     signal_q <= ~pol_in;
                     busy_q   <= 1'b1;
                  end
               end
               ST_HIGH: begin
                  if (phase_q == '0) begin
                     // Completion takes priority over a coincident stop.
                     if (!mode_q && (pulses_q == '0)) begin
                        state_q  <= ST_IDLE;
                        signal_q <= pol_q;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                     end else if (bus.stop[g]) begin
                        state_q  <= ST_IDLE;
                        signal_q <= pol_q;
                        busy_q   <= 1'b0;
                     end else begin
                        if (!mode_q) pulses_q <= pulses_q - CNT_W'(1);
                        if (low_q == '0) begin
                           phase_q <= high_q - CNT_W'(1);
                        end else begin
                           state_q  <= ST_LOW;
                           phase_q  <= low_q - CNT_W'(1);
                           signal_q <= pol_q;
                        end
                     end
                  end else if (bus.stop[g]) begin
                     state_q  <= ST_IDLE;
                     signal_q <= pol_q;
                     busy_q   <= 1'b0;
                  end else begin
                     phase_q <= phase_q - CNT_W'(1);
                  end
               end
               ST_LOW: begin
                  if (bus.stop[g]) begin
                     state_q  <= ST_IDLE;
                     signal_q <= pol_q;
                     busy_q   <= 1'b0;
                  end else if (phase_q == '0) begin
                     state_q  <= ST_HIGH;
                     phase_q  <= high_q - CNT_W'(1);
                     signal_q <= ~pol_q;
                  end else begin
                     phase_q <= phase_q - CNT_W'(1);
                  end
               end
               default: begin
                  state_q  <= ST_IDLE;
                  signal_q <= 1'b0;
                  busy_q   <= 1'b0;
               end
            endcase
         end
      end

      assign bus.signal[g] = signal_q;
      assign bus.busy[g]   = busy_q;
      assign bus.done[g]   = done_q;
   end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen: directed scenarios followed by
// random start/stop traffic, compared every cycle against a reference model
// that derives each waveform from elapsed time since start.
module tb_pulse_train_gen;
   localparam int unsigned CH = 4;
   localparam int unsigned W  = 8;

   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   pulse_train_gen_if #(.CHANNELS(CH), .CNT_W(W)) bus ();

   pulse_train_gen #(.CHANNELS(CH), .CNT_W(W)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: per channel, active flag, cycles since start, latched config.
   bit act    [CH];
   int age    [CH];
   int m_hi   [CH];
   int m_lo   [CH];
   int m_pc   [CH];
   bit m_mode [CH];
   bit m_pol  [CH];
   bit m_done [CH];

   function automatic int burst_total(int c);
      return m_pc[c] * m_hi[c] + (m_pc[c] - 1) * m_lo[c];
   endfunction

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         act[c] = 0; age[c] = 0; m_pol[c] = 0; m_done[c] = 0;
      end
   endtask

   // Apply the rules for one rising edge using the inputs present at that edge.
   task automatic model_edge();
      logic [CH-1:0] pol_v;
      int hi, lo, pc;
`ifdef PULSE_TRAIN_POL_EN
      pol_v = bus.polarity;
`else
      pol_v = '0;
`endif
      for (int c = 0; c < CH; c++) begin
         m_done[c] = 0;
         hi = int'(bus.high_len[c*W +: W]);
         lo = int'(bus.low_len[c*W +: W]);
         pc = int'(bus.pulse_cnt[c*W +: W]);
         if (act[c]) begin
            if (!m_mode[c] && (age[c] + 1 == burst_total(c))) begin
               act[c] = 0; m_done[c] = 1;
            end else if (bus.stop[c]) begin
               act[c] = 0;
            end else begin
               age[c]++;
            end
         end else if (bus.start[c] && !bus.stop[c] && hi != 0 && (bus.mode[c] || pc != 0)) begin
            act[c] = 1; age[c] = 0;
            m_hi[c] = hi; m_lo[c] = lo; m_pc[c] = pc;
            m_mode[c] = bus.mode[c]; m_pol[c] = pol_v[c];
         end
      end
   endtask

   task automatic check(input string tag);
      logic [CH-1:0] es, eb, ed;
      for (int c = 0; c < CH; c++) begin
         if (act[c]) begin
            es[c] = ((age[c] % (m_hi[c] + m_lo[c])) < m_hi[c]) ^ m_pol[c];
            eb[c] = 1'b1;
         end else begin
            es[c] = m_pol[c];
            eb[c] = 1'b0;
         end
         ed[c] = m_done[c];
      end
      checks++;
      assert (bus.signal === es) else begin
         errors++;
         $error("FAIL %s signal observed %b expected %b at %0t", tag, bus.signal, es, $time);
      end
      checks++;
      assert (bus.busy === eb) else begin
         errors++;
         $error("FAIL %s busy observed %b expected %b at %0t", tag, bus.busy, eb, $time);
      end
      checks++;
      assert (bus.done === ed) else begin
         errors++;
         $error("FAIL %s done observed %b expected %b at %0t", tag, bus.done, ed, $time);
      end
   endtask

   // One clock per iteration; start/stop behave as single-edge pulses.
   task automatic tick(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         model_edge();
         #1;
         check(tag);
         bus.start = '0;
         bus.stop  = '0;
      end
   endtask

   task automatic set_ch(input int c, input int hi, input int lo, input int pc,
                         input bit m, input bit p);
      bus.high_len[c*W +: W]  = W'(hi);
      bus.low_len[c*W +: W]   = W'(lo);
      bus.pulse_cnt[c*W +: W] = W'(pc);
      bus.mode[c]             = m;
`ifdef PULSE_TRAIN_POL_EN
      bus.polarity[c]         = p;
`else
      if (p) $display("polarity request ignored in this build");
`endif
   endtask

   initial begin
      reset_n       = 1'b0;
      bus.start     = '0;
      bus.stop      = '0;
      bus.mode      = '0;
      bus.high_len  = '0;
      bus.low_len   = '0;
      bus.pulse_cnt = '0;
`ifdef PULSE_TRAIN_POL_EN
      bus.polarity  = '0;
`endif
      model_reset();
      #12;
      check("reset");
      reset_n = 1'b1;

      // Burst 4/4/3 on ch0.
      set_ch(0, 4, 4, 3, 0, 0);
      bus.start[0] = 1'b1;
      tick("burst", 24);

      // Continuous 5/15 on ch1, stopped during the third low phase.
      set_ch(1, 5, 15, 0, 1, 0);
      bus.start[1] = 1'b1;
      tick("cont", 50);
      bus.stop[1] = 1'b1;
      tick("cont_stop", 5);

      // Edge fields.
      set_ch(2, 0, 3, 2, 0, 0);
      bus.start[2] = 1'b1;
      tick("high0", 4);
      set_ch(2, 3, 0, 2, 0, 0);
      bus.start[2] = 1'b1;
      tick("low0", 9);
      set_ch(3, 3, 3, 0, 0, 0);
      bus.start[3] = 1'b1;
      tick("cnt0", 4);
      set_ch(3, 2, 2, 2, 0, 0);
      bus.start[3] = 1'b1;
      bus.stop[3]  = 1'b1;
      tick("start_stop_idle", 3);

      // Stop on the completion edge: done must still fire.
      set_ch(0, 2, 1, 1, 0, 0);
      bus.start[0] = 1'b1;
      tick("cmpl_pre", 1);
      bus.stop[0] = 1'b1;
      tick("cmpl_stop", 3);

      // All channels together, then restart attempt on busy ch2.
      set_ch(0, 1, 1, 5, 0, 0);
      set_ch(1, 2, 3, 4, 0, 0);
      set_ch(2, 3, 2, 0, 1, 0);
      set_ch(3, 7, 0, 3, 0, 0);
      bus.start = '1;
      tick("indep", 10);
      set_ch(2, 9, 9, 9, 0, 0);
      bus.start[2] = 1'b1;
      tick("indep_restart", 30);
      bus.stop = '1;
      tick("indep_stop", 2);

      // Asynchronous reset in the middle of a burst.
      set_ch(0, 6, 2, 5, 0, 0);
      bus.start[0] = 1'b1;
      tick("pre_rst", 7);
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check("async_rst");
      @(posedge clock);
      #3;
      check("rst_hold");
      reset_n = 1'b1;
      tick("post_rst", 5);

      // Maximum high length.
      set_ch(0, 255, 1, 1, 0, 0);
      bus.start[0] = 1'b1;
      tick("limit", 258);
`ifdef PULSE_TRAIN_POL_EN
      set_ch(0, 255, 1, 1, 0, 1);
      bus.start[0] = 1'b1;
      tick("limit_pol", 260);
`endif

      // Random traffic, including configuration changes while busy.
      for (int i = 0; i < 1500; i++) begin
         for (int c = 0; c < CH; c++) begin
            if ($urandom_range(7) == 0) begin
               set_ch(c, int'($urandom_range(6)), int'($urandom_range(4)),
                      int'($urandom_range(4)), 1'($urandom_range(1)), 1'($urandom_range(1)));
               bus.start[c] = 1'b1;
            end
            if ($urandom_range(39) == 0) bus.stop[c] = 1'b1;
         end
         tick("random", 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pulse_train_gen.md
Name: pulse_train_gen

Overview:
- Synthesizable, multi-channel programmable pulse-train generator.
- Successor to the fixed-pattern, delay-based pulse stimulus blocks.
- Each channel independently produces bursts or continuous trains. High time, low time and pulse count are set at start, in clock cycles.
- Sits beside the `clock` source in test harnesses and timing-stimulus datapaths; drives strobes, enables and LED/scope patterns.

Parameters:
- CHANNELS, 4: number of independent channels.
- CNT_W, 8: width of the high_len, low_len and pulse_cnt fields. Maximum value is 2^CNT_W-1.

Ports:
- clock, input, 1: single rising-edge clock.
- reset_n, input, 1: asynchronous, active-low reset.
- start, input, CHANNELS: per-channel start request, sampled on posedge.
- stop, input, CHANNELS: per-channel abort, sampled on posedge.
- mode, input, CHANNELS: 0 = burst of pulse_cnt pulses; 1 = continuous until stop.
- high_len, input, CHANNELS*CNT_W: high-phase length in cycles. Channel k uses bits [k*CNT_W +: CNT_W].
- low_len, input, CHANNELS*CNT_W: low-phase length in cycles, same packing.
- pulse_cnt, input, CHANNELS*CNT_W: number of pulses in burst mode, same packing.
- signal, output, CHANNELS: generated waveforms.
- busy, output, CHANNELS: channel active (state HIGH or LOW).
- done, output, CHANNELS: one-cycle pulse at normal burst completion.

Behaviour:
- Reset:
  - While reset_n=0, all outputs are 0 immediately, independent of clock.
  - All channels go to IDLE; counters and latched configuration are cleared.
- Channels are fully independent. Per-channel FSM states: IDLE, HIGH, LOW.
- IDLE:
  - signal=0, busy=0.
  - On a posedge with start=1, stop=0, high_len!=0, and (mode=1 or pulse_cnt!=0): latch high_len, low_len, pulse_cnt and mode, then enter HIGH.
  - Otherwise stay in IDLE; a start with zero fields is silently ignored.
- Start latency: when start is sampled at edge E0, signal=1 and busy=1 from E0 onward (registered outputs, visible after E0).
- HIGH:
  - signal=1 for exactly high_len cycles.
  - Then, in burst mode after the last pulse: go to IDLE, signal=0, busy=0, done=1 for one cycle.
  - Else if low_len=0: start the next HIGH directly, so signal stays 1 with no gap.
  - Else: go to LOW.
- LOW: signal=0, busy=1 for exactly low_len cycles, then HIGH.
- Burst total:
  - The burst lasts pulse_cnt*high_len + (pulse_cnt-1)*low_len cycles.
  - There is no trailing low phase.
- Continuous mode: pulse_cnt is ignored; the HIGH/LOW alternation repeats indefinitely.
- Configuration isolation: configuration inputs are not looked at after latching. Changing them mid-train has no effect.
- start while busy is ignored; there is no re-latch and no restart.
- stop:
  - In HIGH or LOW, stop=1 at an edge gives signal=0, busy=0 and IDLE after that edge. done stays 0.
  - stop in IDLE has no effect.
  - start and stop in the same cycle in IDLE: stop wins and the channel stays IDLE.
  - stop on the same edge as burst completion: completion wins and done=1.
- Counters:
  - Down-counters of CNT_W bits load with length-1. No wrap-around is possible.
  - pulse_cnt=2^CNT_W-1 is legal.
- done is registered and never coincides with busy=1 on the same channel.

Optional Feature:
- Macro: PULSE_TRAIN_POL_EN.
- When defined:
  - Adds input port `polarity` (CHANNELS bits), latched at start.
  - A channel with polarity=1 outputs the inverted waveform while busy, and its idle level becomes 1.
  - The level during reset is 0. The first idle cycle after reset is 0, because the latched polarity is cleared.
- When undefined: the port does not exist and all behaviour is as above, with active-high pulses and idle 0.

Test Plan:
1. Burst (CNT_W=8, CHANNELS=4): ch0 start with high=4, low=4, cnt=3, mode=0 at E0 → signal 1 for 4 cycles, 0 for 4, 1 for 4, 0 for 4, 1 for 4. busy is 1 for 20 cycles. done=1 in the first cycle after (signal=0).
2. Continuous: ch1 high=5, low=15, mode=1 → period 20 with 25% duty, repeating. stop asserted in the 3rd period's low phase → signal=0, busy=0 next edge, done stays 0.
3. Edge fields:
   - high=0 → start ignored, busy stays 0.
   - high=3, low=0, cnt=2 → signal 1 for 6 contiguous cycles, then done.
   - cnt=0 with mode=0 → ignored.
4. Independence: all 4 channels started on the same edge with different configs → each matches its own expected waveform. A second start on busy ch2, with new fields, leaves its waveform unchanged.
5. Reset: reset_n dropped mid-burst, between clock edges → signal, busy and done go to 0 immediately. After release, the channel stays IDLE until a new start.
6. Limits: high=255, low=1, cnt=1 → exactly 255 high cycles, then done. With PULSE_TRAIN_POL_EN and polarity=1, the same config gives 255 low cycles and idle 1 afterwards.
